// File: rtl/mem_io_responder.sv
// Byte-wide memory-bus responder: on-chip RAM with 1-cycle registered read,
// plus an IO window holding a TX queue, an RX byte port and a sim-end register.
module mem_io_responder #(
  parameter int unsigned RAM_ADDR_W  = 17,
  parameter int unsigned TXQ_DEPTH   = 8,
  parameter int unsigned FULL_MARGIN = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rdy,
  input  logic        iMEM_rw,
  input  logic [31:0] iMEM_addr,
  input  logic [7:0]  iMEM_dt,
  output logic [7:0]  oMEM_dt,
  output logic        oIO_buffer_full,
  output logic        oIO_drop,
  output logic        oTX_valid,
  output logic [7:0]  oTX_data,
  input  logic        iTX_ready,
  input  logic        iRX_valid,
  input  logic [7:0]  iRX_data,
  output logic        oRX_ready,
  output logic        oSIM_end,
  output logic [7:0]  oSIM_code
);

  localparam int unsigned PW = $clog2(TXQ_DEPTH);
  localparam logic [PW:0]   DEPTH_C  = (PW+1)'(TXQ_DEPTH);
  localparam logic [PW:0]   THRESH_C = (PW+1)'(TXQ_DEPTH - FULL_MARGIN);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  logic [7:0]            ram_q [2**RAM_ADDR_W];
  logic [7:0]            txq_q [TXQ_DEPTH];
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [PW:0]           cnt_q, cnt_d;
  logic [7:0]            mem_dt_q, mem_dt_d;
  logic                  full_q, drop_q, sim_end_q;
  logic [7:0]            sim_code_q;

  logic                  is_io, sel_data, sel_ctrl, bus_wr, bus_rd;
  logic                  ram_we, push_req, push, pop, drop, rx_take, ctrl_wr;
  logic [RAM_ADDR_W-1:0] ram_idx;
  logic                  unused_addr;

  assign unused_addr = ^iMEM_addr[31:18];

  always_comb begin
    is_io    = (iMEM_addr[17:16] == 2'b11);
    ram_idx  = iMEM_addr[RAM_ADDR_W-1:0];
    sel_data = is_io && (iMEM_addr[2:0] == 3'd0);
    sel_ctrl = is_io && (iMEM_addr[2:0] == 3'd4);
    bus_wr   = rdy && iMEM_rw;
    bus_rd   = rdy && !iMEM_rw;
    ram_we   = bus_wr && !is_io;
    ctrl_wr  = bus_wr && sel_ctrl;
    pop      = (cnt_q != '0) && iTX_ready;
    push_req = bus_wr && sel_data;
    // A pop in the same cycle frees a slot, so a push to a full queue survives.
    push     = push_req && ((cnt_q != DEPTH_C) || pop);
    drop     = push_req && !push;
    rx_take  = bus_rd && sel_data && iRX_valid;

    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase

    mem_dt_d = mem_dt_q;
    if (rdy) begin
      if (iMEM_rw)       mem_dt_d = '0;
      else if (!is_io)   mem_dt_d = ram_q[ram_idx];
      else if (sel_data) mem_dt_d = iRX_valid ? iRX_data : '0;
      else if (sel_ctrl) mem_dt_d = {6'b0, iRX_valid, (cnt_q == '0)};
      else               mem_dt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      mem_dt_q   <= '0;
      full_q     <= 1'b0;
      drop_q     <= 1'b0;
      sim_end_q  <= 1'b0;
      sim_code_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      cnt_q     <= cnt_d;
      mem_dt_q  <= mem_dt_d;
      full_q    <= (cnt_d >= THRESH_C);
      drop_q    <= drop;
      sim_end_q <= ctrl_wr;
      if (ctrl_wr) sim_code_q <= iMEM_dt;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) ram_q[ram_idx] <= iMEM_dt;
    if (push)   txq_q[wr_ptr_q] <= iMEM_dt;
  end

  assign oMEM_dt         = mem_dt_q;
  assign oIO_buffer_full = full_q;
  assign oIO_drop        = drop_q;
  assign oTX_valid       = (cnt_q != '0);
  assign oTX_data        = oTX_valid ? txq_q[rd_ptr_q] : '0;
  assign oRX_ready       = rx_take && rst_n;
  assign oSIM_end        = sim_end_q;
  assign oSIM_code       = sim_code_q;

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder: RAM latency, TX queue fill/drop/drain,
// RX and CTRL reads, sim-end register and asynchronous reset.
module tb_mem_io_responder;

  logic        clk = 1'b0;
  logic        rst_n, rdy, iMEM_rw, iTX_ready, iRX_valid;
  logic [31:0] iMEM_addr;
  logic [7:0]  iMEM_dt, iRX_data;
  logic [7:0]  oMEM_dt, oTX_data, oSIM_code;
  logic        oIO_buffer_full, oIO_drop, oTX_valid, oRX_ready, oSIM_end;

  int n_tests = 0;
  int n_fail  = 0;

  mem_io_responder #(.RAM_ADDR_W(17), .TXQ_DEPTH(8), .FULL_MARGIN(2)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .iMEM_rw(iMEM_rw),
    .iMEM_addr(iMEM_addr), .iMEM_dt(iMEM_dt), .oMEM_dt(oMEM_dt),
    .oIO_buffer_full(oIO_buffer_full), .oIO_drop(oIO_drop),
    .oTX_valid(oTX_valid), .oTX_data(oTX_data), .iTX_ready(iTX_ready),
    .iRX_valid(iRX_valid), .iRX_data(iRX_data), .oRX_ready(oRX_ready),
    .oSIM_end(oSIM_end), .oSIM_code(oSIM_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic r, input logic w, input logic [31:0] a, input logic [7:0] d);
    rdy = r; iMEM_rw = w; iMEM_addr = a; iMEM_dt = d;
  endtask

  logic [7:0] drain_exp [8] = '{8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h0A, 8'h00};

  initial begin
    rst_n = 1'b0; iTX_ready = 1'b0; iRX_valid = 1'b1; iRX_data = 8'h77;
    bus(1'b1, 1'b0, 32'h0003_0000, 8'h00);
    tick(); tick();
    chk("reset_outputs",
        {oMEM_dt, oTX_data, oSIM_code, oIO_buffer_full, oIO_drop, oTX_valid, oRX_ready, oSIM_end},
        '0);
    iRX_valid = 1'b0;
    bus(1'b0, 1'b0, 32'h0, 8'h00);
    rst_n = 1'b1;
    tick();

    // 1: RAM write then read, one-cycle latency
    bus(1'b1, 1'b1, 32'h0000_0010, 8'hA5);
    tick();
    chk("ram_wr_dt_zero", oMEM_dt, 8'h00);
    bus(1'b1, 1'b0, 32'h0000_0010, 8'h00);
    tick();
    chk("ram_rd_latency", oMEM_dt, 8'hA5);
    bus(1'b0, 1'b1, 32'h0000_0010, 8'h3C);
    tick();
    chk("rdy0_holds_dt", oMEM_dt, 8'hA5);
    bus(1'b1, 1'b0, 32'h1234_0010, 8'h00);
    tick();
    chk("ram_upper_bits_ignored", oMEM_dt, 8'hA5);

    // 2: fill TX queue, full flag after 6th push, 9th write dropped
    for (int i = 1; i <= 8; i++) begin
      bus(1'b1, 1'b1, 32'h0003_0000, 8'(i));
      tick();
      chk($sformatf("full_after_push%0d", i), oIO_buffer_full, (i >= 6) ? 1 : 0);
    end
    chk("io_wr_dt_zero", oMEM_dt, 8'h00);
    chk("tx_valid_full", oTX_valid, 1'b1);
    chk("tx_head_full", oTX_data, 8'h01);
    chk("no_drop_yet", oIO_drop, 1'b0);
    bus(1'b1, 1'b1, 32'h0003_0000, 8'h09);
    tick();
    chk("drop_pulse", oIO_drop, 1'b1);
    bus(1'b0, 1'b0, 32'h0, 8'h00);
    tick();
    chk("drop_pulse_end", oIO_drop, 1'b0);
    chk("head_after_drop", oTX_data, 8'h01);

    // 3: push and pop together while full, then drain
    iTX_ready = 1'b1;
    bus(1'b1, 1'b1, 32'h0003_0000, 8'h0A);
    tick();
    chk("full_pushpop_no_drop", oIO_drop, 1'b0);
    chk("full_pushpop_head", oTX_data, 8'h02);
    chk("full_pushpop_full", oIO_buffer_full, 1'b1);
    bus(1'b0, 1'b0, 32'h0, 8'h00);
    for (int k = 0; k < 7; k++) begin
      tick();
      chk($sformatf("drain_%0d", k), oTX_data, drain_exp[k]);
    end
    chk("full_low_last", oIO_buffer_full, 1'b0);
    chk("valid_last", oTX_valid, 1'b1);
    tick();
    chk("valid_fall", oTX_valid, 1'b0);
    iTX_ready = 1'b0;

    // 4: RX data read and CTRL status read
    iRX_valid = 1'b1; iRX_data = 8'h5C;
    bus(1'b1, 1'b0, 32'h0003_0000, 8'h00);
    #1;
    chk("rx_ready_pulse", oRX_ready, 1'b1);
    @(posedge clk); #1;
    iRX_valid = 1'b0;
    bus(1'b0, 1'b0, 32'h0, 8'h00);
    #1;
    chk("rx_ready_end", oRX_ready, 1'b0);
    chk("rx_data", oMEM_dt, 8'h5C);
    bus(1'b1, 1'b0, 32'h0003_0004, 8'h00);
    tick();
    chk("ctrl_rd_empty", oMEM_dt, 8'h01);
    bus(1'b1, 1'b0, 32'h0003_0002, 8'h00);
    tick();
    chk("io_unmapped_rd", oMEM_dt, 8'h00);

    // 5: sim-end register, then ignored with rdy low
    bus(1'b1, 1'b1, 32'h0003_0004, 8'h2A);
    tick();
    chk("sim_end_pulse", oSIM_end, 1'b1);
    chk("sim_code", oSIM_code, 8'h2A);
    bus(1'b0, 1'b1, 32'h0003_0004, 8'h55);
    tick();
    chk("sim_end_once", oSIM_end, 1'b0);
    tick();
    chk("sim_end_rdy0", oSIM_end, 1'b0);
    chk("sim_code_rdy0", oSIM_code, 8'h2A);
    bus(1'b0, 1'b1, 32'h0000_0010, 8'h5A);
    tick();
    bus(1'b1, 1'b0, 32'h0000_0010, 8'h00);
    tick();
    chk("ram_rdy0_unchanged", oMEM_dt, 8'hA5);

    // 6: asynchronous reset mid-drain
    for (int i = 0; i < 4; i++) begin
      bus(1'b1, 1'b1, 32'h0003_0000, 8'(8'h11 * (i + 1)));
      tick();
    end
    iTX_ready = 1'b1;
    bus(1'b1, 1'b0, 32'h0000_0010, 8'h00);
    tick();
    chk("pre_reset_head", oTX_data, 8'h22);
    chk("pre_reset_dt", oMEM_dt, 8'hA5);
    bus(1'b0, 1'b0, 32'h0, 8'h00);
    iTX_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", oTX_valid, 1'b0);
    chk("async_rst_full", oIO_buffer_full, 1'b0);
    chk("async_rst_dt", oMEM_dt, 8'h00);
    chk("async_rst_data", oTX_data, 8'h00);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_empty", oTX_valid, 1'b0);
    bus(1'b1, 1'b0, 32'h0000_0010, 8'h00);
    tick();
    chk("ram_survives_reset", oMEM_dt, 8'hA5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_io_responder.md
Name: mem_io_responder

Overview:
Responder end of the byte-wide memory bus driven by the memory controller. It serves one byte per cycle from on-chip RAM with a fixed 1-cycle read latency and decodes a small IO window for a UART-style TX queue, RX byte port and simulation-end register. It sits between the memory controller and the board/testbench IO. It also generates the IO-buffer-full backpressure that the controller consumes.

Parameters:
RAM_ADDR_W, 17, RAM index width; RAM depth is 2**RAM_ADDR_W bytes.
TXQ_DEPTH, 8, TX queue depth in bytes; must be a power of 2 and >= 4.
FULL_MARGIN, 2, free-slot threshold at which oIO_buffer_full asserts.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
rdy  in  1  global enable; low freezes the bus side
iMEM_rw  in  1  1 = write, 0 = read
iMEM_addr  in  32  byte address
iMEM_dt  in  8  write data
oMEM_dt  out  8  read data; valid the cycle after the address
oIO_buffer_full  out  1  TX queue near full
oIO_drop  out  1  1-cycle pulse when a TX write is dropped
oTX_valid  out  1  TX queue non-empty
oTX_data  out  8  head of the TX queue
iTX_ready  in  1  sink accepts oTX_data
iRX_valid  in  1  RX byte available
iRX_data  in  8  RX byte
oRX_ready  out  1  1-cycle pulse when the RX byte is consumed
oSIM_end  out  1  1-cycle pulse on a simulation-end write
oSIM_code  out  8  byte latched on a simulation-end write

Behaviour:
- Reset is asynchronous and active-low; clk is the only clock. While rst_n=0, every output is 0, TX queue pointers and count are 0, and oSIM_code is 0. RAM contents are not reset.
- Decode: iMEM_addr[17:16]==2'b11 selects IO; otherwise RAM at index iMEM_addr[RAM_ADDR_W-1:0]. Upper address bits are ignored. IO registers use iMEM_addr[2:0]; 0x0 = DATA, 0x4 = CTRL; any other IO offset reads 0 and ignores writes.
- Bus side acts only on clk edges with rdy=1. With rdy=0: no RAM write, no queue push, no RX pop, oMEM_dt holds its value, and no pulses are generated.
- RAM read: an address presented at edge N gives oMEM_dt = ram[idx] after edge N+1 (registered output, 1-cycle latency).
- RAM write: ram[idx] <= iMEM_dt at the edge. oMEM_dt after that edge is 0.
- IO write to DATA: pushes iMEM_dt into the TX queue. If the queue is full and no pop happens in the same cycle, the byte is dropped, oIO_drop pulses for 1 cycle and the count is unchanged.
- IO write to CTRL: oSIM_code <= iMEM_dt and oSIM_end pulses for 1 cycle.
- IO read of DATA: if iRX_valid, oMEM_dt <= iRX_data and oRX_ready pulses in the same cycle. Otherwise oMEM_dt <= 0 and there is no pulse.
- IO read of CTRL: oMEM_dt <= {6'b0, iRX_valid, txq_empty}.
- Any IO write gives oMEM_dt = 0 on the next cycle.
- TX queue: circular buffer with log2(TXQ_DEPTH)-bit pointers that wrap naturally, plus a count of width log2(TXQ_DEPTH)+1.
  - oTX_valid = (count != 0).
  - oTX_data = mem[rd_ptr], combinational from registered state.
  - Pop happens on oTX_valid & iTX_ready and is independent of rdy.
  - Push and pop in the same cycle: both occur and the count is unchanged. This includes the full case, where the push is accepted because the pop frees a slot.
- oIO_buffer_full is registered and is 1 when the next count >= TXQ_DEPTH-FULL_MARGIN. The margin absorbs the controller's one-cycle reaction lag plus one in-flight store.

Test Plan:
1. Reset, then write 0xA5 to 0x00000010 and read 0x00000010 on the next cycle -> oMEM_dt=0xA5 exactly one cycle after the read address; all outputs are 0 during reset.
2. Write bytes 0x01..0x08 to 0x30000 with iTX_ready=0 -> count reaches 8; oIO_buffer_full rises after the 6th push; a 9th write 0x09 pulses oIO_drop and is lost.
3. Full queue, iTX_ready=1 while writing 0x0A to 0x30000 in the same cycle -> 0x01 is popped, 0x0A is accepted, oIO_drop=0; the drain order is 0x02..0x08 then 0x0A, and oTX_valid falls after the last byte.
4. iRX_valid=1 with iRX_data=0x5C, read 0x30000 -> oRX_ready pulses once and oMEM_dt=0x5C next cycle. With iRX_valid=0, read 0x30004 with the queue empty -> oMEM_dt=0x01.
5. Write 0x2A to 0x30004 -> oSIM_end pulses for exactly one cycle and oSIM_code=0x2A. Repeat with rdy=0 -> no pulse, oSIM_code unchanged, RAM unchanged.
6. Drop rst_n mid-drain with 3 bytes queued -> oTX_valid, oIO_buffer_full and oMEM_dt go to 0 immediately. After release the queue is empty and RAM still holds the scenario-1 byte 0xA5.
